om_seq_ctrl: RTL and testbench

- Sequencer for one radix-2 online-multiplier residual slice. The slice is combinational; it is instantiated beside this block at the multiplier top.
- Accepts signed-digit operand pairs MSD-first over a valid/ready handshake and maintains the X/Y two's-complement prefix registers.
- Holds the Ws/Wc carry-save residual between iterations and drives the slice each step.
- Runs the online-delay initialisation, then the main phase, then the flush phase, emitting product digits over a second valid/ready handshake.

---
 rtl/om_pkg.sv | 24 ++
 rtl/om_prefix_acc.sv | 50 +++++
 rtl/om_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_om_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/om_pkg.sv
// Shared definitions for the online-multiplier sequencer: signed-digit
// encoding, sequencer FSM states and the default online delay.
package om_pkg;

   localparam logic [1:0] DIG_POS  = 2'b10;
   localparam logic [1:0] DIG_NEG  = 2'b01;
   localparam logic [1:0] DIG_ZERO = 2'b00;

   localparam int DELTA_DEF = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } om_state_t;

   // The illegal code 11 is handled as a zero digit.
   function automatic logic [1:0] dig_clean(input logic [1:0] d);
      return (d == 2'b11) ? DIG_ZERO : d;
   endfunction

endpackage

// File: rtl/om_prefix_acc.sv
// Signed-digit to two's-complement prefix accumulator: digit k has weight
// 2^(WL_XY-2-k). INCL selects whether pfx includes the digit currently at dig.
module om_prefix_acc
   import om_pkg::*;
#(
   parameter int WL_XY = 8,
   parameter int KW    = 4,
   parameter bit INCL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       dig,
   input  logic [KW-1:0]    k,
   output logic [WL_XY-1:0] pfx
);

   localparam logic [WL_XY-1:0] ONE_W = {{(WL_XY-1){1'b0}}, 1'b1};
   localparam logic [KW-1:0]    K_TOP = KW'(WL_XY - 2);

   logic signed [WL_XY-1:0] acc_q;
   logic signed [WL_XY-1:0] wgt;
   logic signed [WL_XY-1:0] term;
   logic        [KW-1:0]    sh;

   always_comb begin
      sh  = K_TOP - k;
      wgt = '0;
      if (k <= K_TOP)
         wgt = signed'(ONE_W << sh);
      case (dig)
         DIG_POS: term = wgt;
         DIG_NEG: term = -wgt;
         default: term = '0;
      endcase
   end

   assign pfx = INCL ? (acc_q + term) : acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_q <= '0;
      else if (clr)
         acc_q <= '0;
      else if (en)
         acc_q <= acc_q + term;
   end

endmodule

// File: rtl/om_seq_ctrl.sv
// Sequencer for one radix-2 online-multiplier residual slice (INIT/RUN/FLUSH).
// Optional build macro OM_SEQ_PERF_EN adds the saturating stall_cnt output.
module om_seq_ctrl
   import om_pkg::*;
#(
   parameter int WL_XY = 8,
   parameter int NDIG  = WL_XY - 1,
   parameter int DELTA = DELTA_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          x_d,
   input  logic [1:0]          y_d,
   output logic                z_valid,
   input  logic                z_ready,
   output logic [1:0]          z_d,
   output logic                done,
   output logic                busy,
   output logic                err,
   output logic [1:0]          slc_x,
   output logic [1:0]          slc_y,
   output logic [WL_XY-1:0]    slc_xY_in,
   output logic [WL_XY-1:0]    slc_yX_in,
   output logic [WL_XY+4:0]    slc_ws_in,
   output logic [WL_XY+4:0]    slc_wc_in,
   input  logic [WL_XY+4:0]    slc_ws_out,
   input  logic [WL_XY+4:0]    slc_wc_out,
   input  logic [1:0]          slc_z
`ifdef OM_SEQ_PERF_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);

   localparam int RW = WL_XY + 5;
   localparam int KW = $clog2(NDIG + DELTA + 1);
   localparam logic [KW-1:0] K_DELTA = KW'(DELTA);
   localparam logic [KW-1:0] K_NDIG  = KW'(NDIG);
   localparam logic [KW-1:0] K_LAST  = KW'(NDIG + DELTA - 1);

   om_state_t      state;
   logic [KW-1:0]  k;
   logic [KW-1:0]  k_inc;
   logic [RW-1:0]  ws_q;
   logic [RW-1:0]  wc_q;
   logic           err_q;
   logic           in_ph;
   logic           out_ph;
   logic           act;
   logic           step;
   logic           acc_en;
   logic           start_op;
   logic           bad_dig;

   // Handshakes are cross-gated so an operand pair and its product digit
   // are always transferred in the same cycle once RUN is reached.
   always_comb begin
      in_ph    = (state == ST_INIT) || (state == ST_RUN);
      out_ph   = (state == ST_RUN) || (state == ST_FLUSH);
      act      = in_ph || (state == ST_FLUSH);
      in_ready = in_ph && ((k < K_DELTA) || z_ready);
      z_valid  = out_ph && ((k >= K_NDIG) || in_valid);
      z_d      = z_valid ? slc_z : DIG_ZERO;
      step     = act && ((k >= K_NDIG) || in_valid) && ((k < K_DELTA) || z_ready);
      acc_en   = step && (k < K_NDIG);
      k_inc    = k + 1'b1;
      slc_x    = in_ph ? dig_clean(x_d) : DIG_ZERO;
      slc_y    = in_ph ? dig_clean(y_d) : DIG_ZERO;
      bad_dig  = in_valid && in_ready && ((x_d == 2'b11) || (y_d == 2'b11));
   end

   assign start_op  = (state == ST_IDLE) && start;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign err       = err_q;
   assign slc_ws_in = ws_q;
   assign slc_wc_in = wc_q;

   om_prefix_acc #(.WL_XY(WL_XY), .KW(KW), .INCL(1'b0)) u_x_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_op),
      .en    (acc_en),
      .dig   (slc_x),
      .k     (k),
      .pfx   (slc_yX_in)
   );

   om_prefix_acc #(.WL_XY(WL_XY), .KW(KW), .INCL(1'b1)) u_y_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_op),
      .en    (acc_en),
      .dig   (slc_y),
      .k     (k),
      .pfx   (slc_xY_in)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         k     <= '0;
         ws_q  <= '0;
         wc_q  <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_INIT;
                  k     <= '0;
                  ws_q  <= '0;
                  wc_q  <= '0;
                  err_q <= 1'b0;
               end
            end
            ST_INIT, ST_RUN, ST_FLUSH: begin
               if (bad_dig)
                  err_q <= 1'b1;
               if (step) begin
                  ws_q <= slc_ws_out;
                  wc_q <= slc_wc_out;
                  k    <= k_inc;
                  if (k == K_LAST)
                     state <= ST_DONE;
                  else if (k_inc >= K_NDIG)
                     state <= ST_FLUSH;
                  else if (k_inc >= K_DELTA)
                     state <= ST_RUN;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef OM_SEQ_PERF_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (start_op)
         stall_cnt <= '0;
      else if (act && !step)
         stall_cnt <= sat_inc16(stall_cnt);
   end
`endif

endmodule

// File: tb/tb_om_seq_ctrl.sv
// Self-checking bench for om_seq_ctrl with a behavioural radix-2 online
// multiplier slice and a value-level product reference.
`timescale 1ns/1ps
module tb_om_seq_ctrl;
   import om_pkg::*;

   localparam int WL_XY = 8;
   localparam int NDIG  = WL_XY - 1;
   localparam int DELTA = 3;
   localparam int RW    = WL_XY + 5;
   localparam int NSTEP = NDIG + DELTA;
   localparam int ONE   = 1 << (NDIG + DELTA);
   localparam int HALF  = ONE / 2;
   localparam int SNW   = 4 + 2 * WL_XY + 2 * RW;

   logic clk = 1'b0;
   logic rst_n, start, in_valid, in_ready, z_valid, z_ready, done, busy, err;
   logic [1:0] x_d, y_d, z_d, slc_x, slc_y, slc_z;
   logic [WL_XY-1:0] slc_xY_in, slc_yX_in;
   logic [RW-1:0] slc_ws_in, slc_wc_in, slc_ws_out, slc_wc_out;
`ifdef OM_SEQ_PERF_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   om_seq_ctrl #(.WL_XY(WL_XY), .NDIG(NDIG), .DELTA(DELTA)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x_d        (x_d),
      .y_d        (y_d),
      .z_valid    (z_valid),
      .z_ready    (z_ready),
      .z_d        (z_d),
      .done       (done),
      .busy       (busy),
      .err        (err),
      .slc_x      (slc_x),
      .slc_y      (slc_y),
      .slc_xY_in  (slc_xY_in),
      .slc_yX_in  (slc_yX_in),
      .slc_ws_in  (slc_ws_in),
      .slc_wc_in  (slc_wc_in),
      .slc_ws_out (slc_ws_out),
      .slc_wc_out (slc_wc_out),
      .slc_z      (slc_z)
`ifdef OM_SEQ_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int dval(input logic [1:0] d);
      case (d)
         2'b10:   return 1;
         2'b01:   return -1;
         default: return 0;
      endcase
   endfunction

   function automatic logic [1:0] denc(input int v);
      if (v > 0) return 2'b10;
      if (v < 0) return 2'b01;
      return 2'b00;
   endfunction

   // Behavioural slice: residual in units of 2^-(NDIG+DELTA), round-to-digit
   // selection once the online delay has elapsed, result split over Ws/Wc.
   int ks = 0;
   int s_w, s_v, s_z, s_wn, s_wc;
   always_comb begin
      s_w = int'($signed(slc_ws_in)) + int'($signed(slc_wc_in));
      s_v = 2 * s_w + dval(slc_x) * int'($signed(slc_xY_in))
                    + dval(slc_y) * int'($signed(slc_yX_in));
      s_z = 0;
      if (ks >= DELTA) begin
         if (s_v >= HALF)
            s_z = 1;
         else if (s_v < -HALF)
            s_z = -1;
      end
      s_wn       = s_v - s_z * ONE;
      s_wc       = s_wn >>> 1;
      slc_ws_out = RW'(s_wn - s_wc);
      slc_wc_out = RW'(s_wc);
      slc_z      = denc(s_z);
   end

   logic [1:0] xop [NDIG];
   logic [1:0] yop [NDIG];
   int zq[$];
   int nom[$];

   task automatic load_ops(input string xs, input string ys);
      for (int i = 0; i < NDIG; i++) begin
         case (xs[i])
            "+": xop[i] = 2'b10;
            "-": xop[i] = 2'b01;
            "X": xop[i] = 2'b11;
            default: xop[i] = 2'b00;
         endcase
         case (ys[i])
            "+": yop[i] = 2'b10;
            "-": yop[i] = 2'b01;
            "X": yop[i] = 2'b11;
            default: yop[i] = 2'b00;
         endcase
      end
   endtask

   task automatic cmp_stream();
      for (int i = 0; i < NDIG; i++)
         chk("z_stream_vs_nominal", (i < zq.size()) ? zq[i] : 99, nom[i]);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {in_ready, z_valid, z_d, done, busy, err}, 0);
      chk({tag, "_slc"}, {slc_x, slc_y, slc_xY_in, slc_yX_in, slc_ws_in, slc_wc_in}, 0);
`ifdef OM_SEQ_PERF_EN
      chk({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
   endtask

   // Called right after a rising edge with the DUT idle.
   task automatic run_op(input int p_in, input int p_out, input bit hold_start, input int abort_k);
      int ni, cyc, stalls, xr, yr, zint, diff, first_step;
      bit exp_err, fire, hs_in, hs_z, pfx_done, prev_stall;
      logic [1:0] zcap;
      logic [SNW-1:0] snap, prev_snap;
      xr = 0; yr = 0; exp_err = 0;
      for (int i = 0; i < NDIG; i++) begin
         xr += dval(xop[i]) * (1 << (NDIG - 1 - i));
         yr += dval(yop[i]) * (1 << (NDIG - 1 - i));
         if (xop[i] == 2'b11 || yop[i] == 2'b11) exp_err = 1;
      end
      zq.delete();
      start = 1'b1; in_valid = 1'b0; z_ready = 1'b0;
      @(posedge clk); #1;
      ks = 0; ni = 0; cyc = 0; stalls = 0; first_step = -1;
      pfx_done = 0; prev_stall = 0; prev_snap = '0;
      if (!hold_start) start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("err_cleared_by_start", err, 0);
      while (ks < NSTEP && cyc < 400) begin
         if (ni < NDIG) begin
            in_valid = (int'($urandom_range(99)) >= p_in);
            x_d = xop[ni];
            y_d = yop[ni];
         end else begin
            in_valid = 1'($urandom_range(1));
            x_d = 2'($urandom);
            y_d = 2'($urandom);
         end
         z_ready = (int'($urandom_range(99)) >= p_out);
         #1;
         snap = {slc_x, slc_y, slc_xY_in, slc_yX_in, slc_ws_in, slc_wc_in};
         if (ks == abort_k) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk_all_zero("async_reset");
            return;
         end
         if (prev_stall) chk("slc_stable_in_stall", snap, prev_snap);
         chk("in_ready", in_ready, (ks < NDIG) && (ks < DELTA || z_ready));
         chk("z_valid", z_valid, (ks >= DELTA) && (ks >= NDIG || in_valid));
         chk("busy_active", busy, 1);
         if (ks == NDIG && !pfx_done) begin
            pfx_done = 1;
            chk("x_prefix", $signed(slc_yX_in), xr);
            chk("y_prefix", $signed(slc_xY_in), yr);
         end
         fire  = (ks >= NDIG || in_valid) && (ks < DELTA || z_ready);
         hs_in = in_valid && in_ready;
         hs_z  = z_valid && z_ready;
         zcap  = z_d;
         if (fire && first_step < 0) first_step = cyc;
         if (!fire) stalls++;
         prev_stall = !fire;
         prev_snap  = snap;
         @(posedge clk); #1;
         if (hs_in) ni++;
         if (hs_z) zq.push_back(dval(zcap));
         if (fire) ks++;
         cyc++;
      end
      chk("step_budget", ks, NSTEP);
      in_valid = 1'b1; z_ready = 1'b1;
      #1;
      chk("done_pulse", done, 1);
      chk("in_ready_in_done", in_ready, 0);
      chk("z_valid_in_done", z_valid, 0);
      if (p_in == 0 && p_out == 0) chk("done_latency", cyc - first_step, 10);
`ifdef OM_SEQ_PERF_EN
      chk("stall_cnt", stall_cnt, stalls);
`endif
      chk("err_at_done", err, exp_err);
      chk("operands_accepted", ni, NDIG);
      chk("z_digits_emitted", zq.size(), NDIG);
      zint = 0;
      for (int i = 0; i < zq.size() && i < NDIG; i++)
         zint += zq[i] * (1 << (NDIG - 1 - i));
      diff = zint * (1 << NDIG) - xr * yr;
      chk("product_within_lsb", (diff <= (1 << NDIG)) && (diff >= -(1 << NDIG)), 1);
      @(posedge clk); #1;
      chk("idle_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("err_sticky_idle", err, exp_err);
      start = 1'b0; in_valid = 1'b0; z_ready = 1'b0;
      @(posedge clk); #1;
      chk("still_idle", busy, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; z_ready = 1'b0;
      x_d = 2'b00; y_d = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", busy, 0);

      load_ops("+000000", "+000000");
      run_op(0, 0, 1'b0, -1);
      nom = zq;
      for (int i = 0; i < NDIG; i++)
         chk("half_sq_digits", nom[i], (i == 0) ? 1 : (i == 1) ? -1 : 0);

      load_ops("+++++++", "-------");
      run_op(0, 0, 1'b0, -1);

      for (int r = 0; r < 3; r++) begin
         load_ops("+000000", "+000000");
         run_op(40, 40, 1'b0, -1);
         cmp_stream();
      end

      load_ops("+0X0000", "+000000");
      run_op(30, 30, 1'b0, -1);
      cmp_stream();

      load_ops("+000000", "+000000");
      run_op(0, 0, 1'b0, 5);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1; z_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_busy_after_abort", busy, 0);
         chk("no_done_after_abort", done, 0);
         chk("no_z_after_abort", z_valid, 0);
      end
      in_valid = 1'b0; z_ready = 1'b0;
      run_op(0, 0, 1'b0, -1);
      cmp_stream();

      load_ops("+000000", "+000000");
      run_op(20, 20, 1'b1, -1);
      cmp_stream();

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NDIG; i++) begin
            xop[i] = denc(int'($urandom_range(2)) - 1);
            yop[i] = denc(int'($urandom_range(2)) - 1);
         end
         run_op(25, 25, 1'b0, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
